// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : EXE-stage sequencer for the shared multiply/divide datapath:
//             start/cancel strobes, pipeline stall request, HI/LO write.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_validE,
    input  logic [1:0] op_typeE,
    input  logic       divisor_zeroE,
    input  logic       flushE,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_cancel,
    output logic       stall_req,
    output logic       hilo_we,
    output logic       dbz,
    output logic       busy
);

    if (MUL_LAT < 2 || MUL_LAT > 63) begin : g_bad_mul_lat
        $error("muldiv_ctrl: MUL_LAT must lie in 2..63");
    end
    if (DIV_LAT < 2 || DIV_LAT > 63) begin : g_bad_div_lat
        $error("muldiv_ctrl: DIV_LAT must lie in 2..63");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The accept cycle is the first stall cycle, so RUN lasts LAT-1 cycles.
    localparam logic [5:0] C_MUL_LOAD = 6'(MUL_LAT - 2);
    localparam logic [5:0] C_DIV_LOAD = 6'(DIV_LAT - 2);

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic [1:0] md_op_q, md_op_d;

    logic w_is_div;
    logic w_div_by_zero;
    logic w_accept;
    logic w_start;
    logic w_cancel;
    logic w_stall;
    logic w_hilo;
    logic w_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= 6'd0;
            md_op_q <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            md_op_q <= md_op_d;
        end
    end

    always_comb begin
        w_is_div      = op_typeE[1];
        w_div_by_zero = w_is_div && divisor_zeroE;
        w_accept      = (state_q == S_IDLE) && op_validE && !flushE && !w_div_by_zero;

        state_d  = state_q;
        count_d  = count_q;
        md_op_d  = md_op_q;
        w_start  = 1'b0;
        w_cancel = 1'b0;
        w_stall  = 1'b0;
        w_hilo   = 1'b0;
        w_dbz    = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_dbz = op_validE && !flushE && w_div_by_zero;
                if (w_accept) begin
                    w_start = 1'b1;
                    w_stall = 1'b1;
                    md_op_d = op_typeE;
                    count_d = w_is_div ? C_DIV_LOAD : C_MUL_LOAD;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flushE) begin
                    w_cancel = 1'b1;
                    count_d  = 6'd0;
                    state_d  = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (count_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - 6'd1;
                    end
                end
            end
            // The finished instruction still sits in EXE here, so op_validE is ignored.
            S_DONE: begin
                w_hilo  = !flushE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = 6'd0;
            end
        endcase
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts.
    assign md_start  = rst_n & w_start;
    assign md_cancel = rst_n & w_cancel;
    assign stall_req = rst_n & w_stall;
    assign hilo_we   = rst_n & w_hilo;
    assign dbz       = rst_n & w_dbz;
    assign busy      = rst_n & (state_q != S_IDLE);
    assign md_op     = md_op_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Scoreboard bench for muldiv_ctrl; directed stimulus queues the
//             expected strobes, a monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    localparam int K_START  = 0;
    localparam int K_CANCEL = 1;
    localparam int K_HILO   = 2;
    localparam int K_DBZ    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_validE;
    logic [1:0] op_typeE;
    logic       divisor_zeroE;
    logic       flushE;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_cancel;
    logic       stall_req;
    logic       hilo_we;
    logic       dbz;
    logic       busy;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] op;
    } ev_t;

    ev_t exp_q[$];
    int  cyc         = 0;
    int  stall_total = 0;
    int  vectors     = 0;
    int  miscompares = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_validE    (op_validE),
        .op_typeE     (op_typeE),
        .divisor_zeroE(divisor_zeroE),
        .flushE       (flushE),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_cancel    (md_cancel),
        .stall_req    (stall_req),
        .hilo_we      (hilo_we),
        .dbz          (dbz),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_START:  return "md_start";
            K_CANCEL: return "md_cancel";
            K_HILO:   return "hilo_we";
            default:  return "dbz";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [1:0] op);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s: strobe seen at cycle %0d, expected none", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL event_order: got %s@%0d, expected %s@%0d", kname(kind), cyc, kname(e.kind), e.cyc);
        end else if ((kind == K_HILO || kind == K_CANCEL) && md_op !== e.op) begin
            miscompares++;
            $display("FAIL md_op_at_%s: got %0d, expected %0d", kname(kind), md_op, e.op);
        end
    endtask

    // Monitor: compares each strobe the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_req) stall_total++;
            if (md_start)  pop_cmp(K_START);
            if (md_cancel) pop_cmp(K_CANCEL);
            if (hilo_we)   pop_cmp(K_HILO);
            if (dbz)       pop_cmp(K_DBZ);
            if (md_start || md_cancel || hilo_we)
                check("strobe_exclusive", 32'(md_start) + 32'(md_cancel) + 32'(hilo_we), 1);
        end
    end

    task automatic chk_all_zero(input string tag);
        check({tag, "_md_start"},  md_start,  0);
        check({tag, "_md_op"},     md_op,     0);
        check({tag, "_md_cancel"}, md_cancel, 0);
        check({tag, "_stall_req"}, stall_req, 0);
        check({tag, "_hilo_we"},   hilo_we,   0);
        check({tag, "_dbz"},       dbz,       0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Issue one op at posedge+1; flush_at<0: none, 1..lat-1: cancel in RUN, lat: flush in DONE.
    task automatic run_op(input logic [1:0] op, input int lat, input bit hold,
                          input int flush_at, input bit dz);
        int t0, s0, last, exp_stall;
        t0 = cyc;
        s0 = stall_total;
        op_validE     = 1'b1;
        op_typeE      = op;
        divisor_zeroE = dz;
        flushE        = 1'b0;
        push_ev(K_START, t0, op);
        if (flush_at > 0 && flush_at < lat) push_ev(K_CANCEL, t0 + flush_at, op);
        else if (flush_at < 0)             push_ev(K_HILO, t0 + lat, op);
        #1;
        check("accept_busy", busy, 0);
        check("accept_stall", stall_req, 1);
        last = (flush_at > 0) ? flush_at : lat;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == flush_at) flushE = 1'b1;
            #1;
            check("run_busy", busy, 1);
            check("run_md_op", md_op, op);
        end
        @(posedge clk); #1;
        flushE = 1'b0;
        if (!hold) op_validE = 1'b0;
        divisor_zeroE = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        exp_stall = (flush_at > 0 && flush_at < lat) ? flush_at : lat;
        check("stall_cycles", stall_total - s0, exp_stall);
    endtask

    initial begin
        rst_n         = 1'b0;
        op_validE     = 1'b1;
        op_typeE      = 2'b00;
        divisor_zeroE = 1'b0;
        flushE        = 1'b0;
        #2;
        chk_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_held");

        // Release with a mult already waiting: accepted on the very next edge.
        rst_n = 1'b1;
        run_op(2'b00, MUL_LAT, 1'b0, -1, 1'b0);

        run_op(2'b11, DIV_LAT, 1'b0, -1, 1'b0);
        run_op(2'b10, DIV_LAT, 1'b0, 10, 1'b0);
        run_op(2'b01, MUL_LAT, 1'b0, MUL_LAT, 1'b0);
        run_op(2'b00, MUL_LAT, 1'b0, -1, 1'b1);

        // Back-to-back mults: the second stays in EXE through DONE.
        run_op(2'b00, MUL_LAT, 1'b1, -1, 1'b0);
        run_op(2'b00, MUL_LAT, 1'b0, -1, 1'b0);

        // Flushed op in IDLE (div by zero too): nothing happens.
        @(posedge clk); #1;
        op_validE = 1'b1; op_typeE = 2'b10; divisor_zeroE = 1'b1; flushE = 1'b1;
        #1;
        check("idle_flush_start", md_start, 0);
        check("idle_flush_stall", stall_req, 0);
        check("idle_flush_dbz", dbz, 0);
        @(posedge clk); #1;
        op_validE = 1'b0; divisor_zeroE = 1'b0; flushE = 1'b0;
        #1;
        check("idle_flush_busy", busy, 0);

        // Divide by zero: dbz one cycle, no start, no stall.
        @(posedge clk); #1;
        op_validE = 1'b1; op_typeE = 2'b10; divisor_zeroE = 1'b1;
        push_ev(K_DBZ, cyc, 2'b10);
        #1;
        check("dbz_start", md_start, 0);
        check("dbz_stall", stall_req, 0);
        @(posedge clk); #1;
        op_validE = 1'b0; divisor_zeroE = 1'b0;
        #1;
        check("dbz_busy", busy, 0);

        // Reset asserted at RUN cycle 2 of a div.
        @(posedge clk); #1;
        op_validE = 1'b1; op_typeE = 2'b10;
        push_ev(K_START, cyc, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_midrun");
        @(posedge clk); #1;
        chk_all_zero("rst_midrun_held");
        rst_n    = 1'b1;
        op_typeE = 2'b00;
        run_op(2'b00, MUL_LAT, 1'b0, -1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
